// File: rtl/updown_counter_mod.sv
// Modulo-N up/down counter with programmable step, clamped parallel load,
// terminal-count pulses and sticky flags. Define CNT_SAT_EN for the saturating build.
module updown_counter_mod #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      STEP_W  = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              en_i,
    input  logic [1:0]        up_down_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic              clr_flags_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              tc_up_o,
    output logic              tc_dn_o,
    output logic              ovf_o,
    output logic              unf_o
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_up_q, tc_up_d;
    logic             tc_dn_q, tc_dn_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   count_ext_s;
    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   max_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    mode_e            mode_s;

    // Clamp an out-of-range load value to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v > MAX_VAL) begin
            r = MAX_VAL;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign mode_s      = mode_e'(up_down_i);
    assign count_ext_s = {1'b0, count_q};
    assign step_ext_s  = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign max_ext_s   = {1'b0, MAX_VAL};
    assign sum_s       = count_ext_s + step_ext_s;
    assign diff_s      = count_ext_s - step_ext_s;

`ifndef CNT_SAT_EN
    // Wrap results: modulus is MAX_VAL+1, kept one bit wider than the count.
    localparam logic [WIDTH:0] MOD_VAL = {1'b0, MAX_VAL} + {{WIDTH{1'b0}}, 1'b1};
    logic [WIDTH:0] wrap_up_s;
    logic [WIDTH:0] wrap_dn_s;
    assign wrap_up_s = sum_s - MOD_VAL;
    assign wrap_dn_s = count_ext_s + MOD_VAL - step_ext_s;
`endif

    // Next count, crossing pulses and sticky flags; a crossing beats clr_flags.
    always_comb begin
        count_d = count_q;
        tc_up_d = 1'b0;
        tc_dn_d = 1'b0;
        ovf_d   = ovf_q & ~clr_flags_i;
        unf_d   = unf_q & ~clr_flags_i;
        case (mode_s)
            MODE_LOAD: begin
                count_d = clamp_load(load_val_i);
            end
            MODE_UP: begin
                if (!en_i) begin
                    count_d = count_q;
                end else if (sum_s > max_ext_s) begin
`ifdef CNT_SAT_EN
                    count_d = MAX_VAL;
`else
                    count_d = wrap_up_s[WIDTH-1:0];
`endif
                    tc_up_d = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = sum_s[WIDTH-1:0];
                end
            end
            MODE_DOWN: begin
                if (!en_i) begin
                    count_d = count_q;
                end else if (step_ext_s > count_ext_s) begin
`ifdef CNT_SAT_EN
                    count_d = {WIDTH{1'b0}};
`else
                    count_d = wrap_dn_s[WIDTH-1:0];
`endif
                    tc_dn_d = 1'b1;
                    unf_d   = 1'b1;
                end else begin
                    count_d = diff_s[WIDTH-1:0];
                end
            end
            MODE_HOLD: begin
                count_d = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= {WIDTH{1'b0}};
            tc_up_q <= 1'b0;
            tc_dn_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_up_q <= tc_up_d;
            tc_dn_q <= tc_dn_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_o = count_q;
    assign tc_up_o = tc_up_q;
    assign tc_dn_o = tc_dn_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod (WIDTH=8, STEP_W=4, MAX_VAL=9): vector table,
// hand-written reset sequence and random traffic against an arithmetic model.
module tb_updown_counter_mod;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [1:0] ud;
    logic [3:0] step;
    logic [7:0] load_val;
    logic       clr;
    logic [7:0] count;
    logic       tc_up, tc_dn, ovf, unf;

    int n_tests = 0;
    int n_fail  = 0;

    int m_count;
    bit m_tcu, m_tcd, m_ovf, m_unf;

    typedef struct {
        bit       en;
        bit [1:0] ud;
        int       step;
        int       lv;
        bit       clr;
        int       ec;
        bit       etu, etd, eo, eu;
    } vec_t;

    vec_t tbl[$];

    updown_counter_mod #(.WIDTH(8), .STEP_W(4), .MAX_VAL(8'd9)) dut (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en), .up_down_i(ud),
        .step_i(step), .load_val_i(load_val), .clr_flags_i(clr),
        .count_o(count), .tc_up_o(tc_up), .tc_dn_o(tc_dn),
        .ovf_o(ovf), .unf_o(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int ec, input bit etu, input bit etd,
                             input bit eo, input bit eu);
        check({tag, ".count"}, {24'd0, count}, ec);
        check({tag, ".tc_up"}, {31'd0, tc_up}, {31'd0, etu});
        check({tag, ".tc_dn"}, {31'd0, tc_dn}, {31'd0, etd});
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, ".unf"}, {31'd0, unf}, {31'd0, eu});
    endtask

    // Reference: plain integer arithmetic on the counter's rules.
    task automatic model_apply(input bit e, input bit [1:0] u, input int s, input int lv, input bit c);
        int t;
        m_tcu = 1'b0;
        m_tcd = 1'b0;
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (u == 2'b11) begin
            m_count = (lv > MAXV) ? MAXV : lv;
        end else if (e && u == 2'b01) begin
            t = m_count + s;
            if (t > MAXV) begin
                m_tcu = 1'b1;
                m_ovf = 1'b1;
`ifdef CNT_SAT_EN
                t = MAXV;
`else
                t = t - (MAXV + 1);
`endif
            end
            m_count = t;
        end else if (e && u == 2'b10) begin
            t = m_count - s;
            if (t < 0) begin
                m_tcd = 1'b1;
                m_unf = 1'b1;
`ifdef CNT_SAT_EN
                t = 0;
`else
                t = t + (MAXV + 1);
`endif
            end
            m_count = t;
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_tcu = 1'b0; m_tcd = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // Drive one cycle of inputs, step past the edge, advance the model.
    task automatic apply(input bit e, input bit [1:0] u, input int s, input int lv, input bit c);
        logic [31:0] sv, lvv;
        sv  = s;
        lvv = lv;
        en = e; ud = u; step = sv[3:0]; load_val = lvv[7:0]; clr = c;
        @(posedge clk);
        #1;
        model_apply(e, u, s, lv, c);
    endtask

    function automatic vec_t mk(input bit e, input bit [1:0] u, input int s, input int lv, input bit c,
                                input int ec, input bit etu, input bit etd, input bit eo, input bit eu);
        vec_t v;
        v.en = e; v.ud = u; v.step = s; v.lv = lv; v.clr = c;
        v.ec = ec; v.etu = etu; v.etd = etd; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    initial begin
        reset_n = 1'b0;
        en = 1'b0; ud = 2'b00; step = 4'd0; load_val = 8'd0; clr = 1'b0;
        model_reset();

`ifdef CNT_SAT_EN
        tbl.push_back(mk(1, 2'b11, 0, 8,   0, 8, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b01, 3, 0,   0, 9, 1, 0, 1, 0));
        tbl.push_back(mk(1, 2'b11, 0, 1,   0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 2'b10, 4, 0,   0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 2'b11, 0, 6,   0, 6, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2'b01, 3, 0,   0, 9, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2'b10, 9, 0,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b11, 0, 200, 0, 9, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2'b01, 1, 0,   1, 9, 1, 0, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0,   1, 9, 0, 0, 0, 0));
`else
        for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 2'b01, 1, 0, 0, i, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b01, 1, 0,   0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 2'b01, 1, 0,   0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 2'b01, 1, 0,   0, 2, 0, 0, 1, 0));
        tbl.push_back(mk(1, 2'b10, 3, 0,   0, 9, 0, 1, 1, 1));
        tbl.push_back(mk(0, 2'b10, 3, 0,   0, 9, 0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b11, 0, 200, 0, 9, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2'b11, 0, 5,   0, 5, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2'b11, 0, 8,   0, 8, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2'b01, 3, 0,   1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b01, 0, 0,   0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 0,   0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 7, 0,   0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b10, 1, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b10, 9, 0,   0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 2'b01, 9, 0,   0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 2'b01, 9, 0,   0, 9, 0, 0, 1, 1));
`endif

        repeat (2) @(posedge clk);
        #1;
        check_all("reset_init", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].ud, tbl[i].step, tbl[i].lv, tbl[i].clr);
            check_all($sformatf("vec%0d", i), tbl[i].ec, tbl[i].etu, tbl[i].etd, tbl[i].eo, tbl[i].eu);
        end

        // Async reset mid-count with ovf set, then reset held across a load.
        apply(1, 2'b11, 0, 8, 0);
        apply(1, 2'b01, 3, 0, 0);
        apply(1, 2'b11, 0, 7, 0);
        check_all("pre_reset", 7, 0, 0, 1, m_unf);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("async_reset", 0, 0, 0, 0, 0);
        en = 1'b1; ud = 2'b11; load_val = 8'd5;
        @(posedge clk);
        #1;
        check_all("reset_over_load", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        apply(1, 2'b01, 1, 0, 0);
        check_all("first_after_reset", 1, 0, 0, 0, 0);

        // Random traffic against the model; steps kept within the legal range.
        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, MAXV)), int'($urandom_range(0, 255)),
                  $urandom_range(0, 7) == 0);
            check_all($sformatf("rnd%0d", k), m_count, m_tcu, m_tcd, m_ovf, m_unf);
            check("rnd_tc_excl", {31'd0, tc_up & tc_dn}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
